user_locked_regfile: RTL and testbench

Parametrised bank of user-owned data registers with per-register lock/ownership state, owner-only writes, administrator release, a single-cycle request/acknowledge interface and a saturating access-violation counter. Sits between the shared configuration bus and the security-sensitive control fields, and is the multi-register, multi-user generalisation of the single user-locked register.

---
 rtl/user_locked_regfile_if.sv | 30 +++
 rtl/user_locked_regfile.sv | 183 ++++++++++++++++++
 tb/tb_user_locked_regfile.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/user_locked_regfile_if.sv
// Request/acknowledge bus for user_locked_regfile: requester drives the
// master side, the register bank drives the slave side.
interface user_locked_regfile_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int ID_W     = 2
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                       req;
    logic [1:0]                 op;
    logic [ADDR_W-1:0]          addr;
    logic [ID_W-1:0]            usr_id;
    logic [DATA_W-1:0]          wr_data;
    logic                       ack;
    logic                       err;
    logic [NUM_REGS*DATA_W-1:0] data_out;
    logic [NUM_REGS-1:0]        locked;
    logic [7:0]                 viol_cnt;

    modport master (
        output req, op, addr, usr_id, wr_data,
        input  ack, err, data_out, locked, viol_cnt
    );

    modport slave (
        input  req, op, addr, usr_id, wr_data,
        output ack, err, data_out, locked, viol_cnt
    );
endinterface

// File: rtl/user_locked_regfile.sv
// Bank of owner-locked data registers with admin release and a saturating
// violation counter. Define ULR_AUTO_UNLOCK_EN to add per-register lock timeouts.
module user_locked_regfile #(
    parameter int              DATA_W   = 8,
    parameter int              NUM_REGS = 4,
    parameter int              ID_W     = 2,
    parameter logic [ID_W-1:0] ADMIN_ID = 2'h3,
    parameter int              TIMEOUT  = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    user_locked_regfile_if.slave bus
);
    localparam int ADDR_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_LOCK   = 2'b10;
    localparam logic [1:0] OP_UNLOCK = 2'b11;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_st_e;

    logic [DATA_W-1:0] data_q  [NUM_REGS];
    logic [DATA_W-1:0] data_d  [NUM_REGS];
    lock_st_e          st_q    [NUM_REGS];
    lock_st_e          st_d    [NUM_REGS];
    logic [ID_W-1:0]   owner_q [NUM_REGS];
    logic [ID_W-1:0]   owner_d [NUM_REGS];
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [7:0]        viol_q, viol_d;
    logic [NUM_REGS-1:0] hit_s;

`ifdef ULR_AUTO_UNLOCK_EN
    localparam int TMR_W = $clog2(TIMEOUT);
    logic [TMR_W-1:0]    tmr_q [NUM_REGS];
    logic [TMR_W-1:0]    tmr_d [NUM_REGS];
    logic [NUM_REGS-1:0] restart_s;
`endif

    // Request decode, per-register lock FSM next state and violation counting
    always_comb begin
        data_d  = data_q;
        st_d    = st_q;
        owner_d = owner_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        viol_d  = viol_q;
        hit_s   = '0;
`ifdef ULR_AUTO_UNLOCK_EN
        tmr_d     = tmr_q;
        restart_s = '0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.addr == ADDR_W'(i)) begin
                hit_s[i] = 1'b1;
            end else begin
                hit_s[i] = 1'b0;
            end
        end

        if (bus.req) begin
            ack_d = 1'b1;
            if (bus.op == OP_NOP) begin
                err_d = 1'b0;
            end else if (hit_s == '0) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (hit_s[i]) begin
                        case (bus.op)
                            OP_WRITE: begin
                                if (st_q[i] == ST_LOCKED && owner_q[i] == bus.usr_id) begin
                                    data_d[i] = bus.wr_data;
`ifdef ULR_AUTO_UNLOCK_EN
                                    restart_s[i] = 1'b1;
`endif
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            OP_LOCK: begin
                                if (st_q[i] == ST_UNLOCKED) begin
                                    st_d[i]    = ST_LOCKED;
                                    owner_d[i] = bus.usr_id;
`ifdef ULR_AUTO_UNLOCK_EN
                                    restart_s[i] = 1'b1;
`endif
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            OP_UNLOCK: begin
                                if (st_q[i] == ST_LOCKED &&
                                    (owner_q[i] == bus.usr_id || bus.usr_id == ADMIN_ID)) begin
                                    st_d[i]    = ST_UNLOCKED;
                                    owner_d[i] = '0;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            default: begin
                                err_d = 1'b0;
                            end
                        endcase
                    end else begin
                        data_d[i] = data_q[i];
                    end
                end
            end
            if (err_d && viol_q != 8'hFF) begin
                viol_d = viol_q + 8'h01;
            end else begin
                viol_d = viol_q;
            end
        end else begin
            ack_d = 1'b0;
            err_d = 1'b0;
        end

`ifdef ULR_AUTO_UNLOCK_EN
        // An owner write in the expiry cycle restarts the timer instead of expiring
        for (int i = 0; i < NUM_REGS; i++) begin
            if (restart_s[i]) begin
                tmr_d[i] = '0;
            end else if (st_q[i] == ST_LOCKED && tmr_q[i] == TMR_W'(TIMEOUT - 1)) begin
                tmr_d[i]   = '0;
                st_d[i]    = ST_UNLOCKED;
                owner_d[i] = '0;
            end else if (st_d[i] == ST_LOCKED) begin
                tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end else begin
                tmr_d[i] = '0;
            end
        end
`endif
    end

    // State and response registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i]  <= '0;
                st_q[i]    <= ST_UNLOCKED;
                owner_q[i] <= '0;
`ifdef ULR_AUTO_UNLOCK_EN
                tmr_q[i]   <= '0;
`endif
            end
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            viol_q <= 8'h00;
        end else begin
            data_q  <= data_d;
            st_q    <= st_d;
            owner_q <= owner_d;
`ifdef ULR_AUTO_UNLOCK_EN
            tmr_q   <= tmr_d;
`endif
            ack_q  <= ack_d;
            err_q  <= err_d;
            viol_q <= viol_d;
        end
    end

    // Present register contents and lock bits straight from the flops
    always_comb begin
        bus.data_out = '0;
        bus.locked   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            bus.data_out[i*DATA_W +: DATA_W] = data_q[i];
            bus.locked[i]                    = (st_q[i] == ST_LOCKED);
        end
    end

    assign bus.ack      = ack_q;
    assign bus.err      = err_q;
    assign bus.viol_cnt = viol_q;

endmodule

// File: tb/tb_user_locked_regfile.sv
// Scoreboard bench for user_locked_regfile: driver updates a rule-level model
// and queues expected responses; a monitor compares them against each ack.
module tb_user_locked_regfile;
    localparam int         DW    = 8;
    localparam int         NR    = 3;
    localparam int         IW    = 2;
    localparam int         TO    = 4;
    localparam logic [1:0] ADMIN = 2'h3;
`ifdef ULR_AUTO_UNLOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int               edge_n;
        logic             er;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    lk;
        logic [7:0]       viol;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    logic [7:0] m_data [NR];
    bit         m_lock [NR];
    logic [1:0] m_own  [NR];
    int         m_dl   [NR];
    int         m_viol;

    user_locked_regfile_if #(.DATA_W(DW), .NUM_REGS(NR), .ID_W(IW)) bus ();

    user_locked_regfile #(
        .DATA_W(DW), .NUM_REGS(NR), .ID_W(IW), .ADMIN_ID(ADMIN), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) begin
            m_data[i] = 8'h00;
            m_lock[i] = 1'b0;
            m_own[i]  = 2'b00;
            m_dl[i]   = 0;
        end
        m_viol = 0;
    endfunction

    // Locks whose deadline edge has been reached are released
    function automatic void expire(input int upto);
        if (AUTO) begin
            for (int i = 0; i < NR; i++) begin
                if (m_lock[i] && m_dl[i] <= upto) begin
                    m_lock[i] = 1'b0;
                    m_own[i]  = 2'b00;
                end
            end
        end
    endfunction

    function automatic exp_t snap(input int e, input logic er);
        exp_t x;
        x.edge_n = e;
        x.er     = er;
        x.viol   = 8'(m_viol);
        for (int i = 0; i < NR; i++) begin
            x.data[i*DW +: DW] = m_data[i];
            x.lk[i]            = m_lock[i];
        end
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic send(input logic [1:0] op, input int a, input logic [1:0] id,
                        input logic [7:0] wd);
        int   e;
        logic er;
        @(negedge clk);
        bus.req = 1'b1; bus.op = op; bus.addr = 2'(a); bus.usr_id = id; bus.wr_data = wd;
        e  = edge_cnt + 1;
        er = 1'b0;
        expire(e - 1);
        if (op == 2'b00) begin
            er = 1'b0;
        end else if (a >= NR) begin
            er = 1'b1;
        end else if (op == 2'b01) begin
            if (m_lock[a] && m_own[a] == id) begin
                m_data[a] = wd;
                m_dl[a]   = e + TO;
            end else er = 1'b1;
        end else if (op == 2'b10) begin
            if (!m_lock[a]) begin
                m_lock[a] = 1'b1;
                m_own[a]  = id;
                m_dl[a]   = e + TO;
            end else er = 1'b1;
        end else begin
            if (m_lock[a] && (m_own[a] == id || id == ADMIN)) begin
                m_lock[a] = 1'b0;
                m_own[a]  = 2'b00;
            end else er = 1'b1;
        end
        if (er && m_viol < 255) m_viol++;
        expire(e);
        sb_q.push_back(snap(e, er));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.req = 1'b0;
        end
    endtask

    // Reset edge carries a WRITE that must be discarded
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = 1'b1; bus.op = 2'b01; bus.addr = 2'd0; bus.usr_id = 2'd2; bus.wr_data = 8'hFF;
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 1'b0;
        model_clear();
        chk("rst_ack",    32'(bus.ack),      32'd0);
        chk("rst_err",    32'(bus.err),      32'd0);
        chk("rst_data",   32'(bus.data_out), 32'd0);
        chk("rst_locked", 32'(bus.locked),   32'd0);
        chk("rst_viol",   32'(bus.viol_cnt), 32'd0);
    endtask

    // Monitor: every ack consumes one expected response from the same edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (bus.ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack: got ack at edge %0d, expected no ack", edge_cnt);
            end else begin
                e = sb_q.pop_front();
                if (e.edge_n != edge_cnt || bus.err !== e.er || bus.data_out !== e.data ||
                    bus.locked !== e.lk || bus.viol_cnt !== e.viol) begin
                    failures++;
                    $display("FAIL resp: got edge=%0d err=%b data=%h locked=%b viol=%0d, expected edge=%0d err=%b data=%h locked=%b viol=%0d",
                             edge_cnt, bus.err, bus.data_out, bus.locked, bus.viol_cnt,
                             e.edge_n, e.er, e.data, e.lk, e.viol);
                end
            end
        end else if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL err_without_ack: got err=%b, expected 0", bus.err);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        bus.req = 1'b1; bus.op = 2'b10; bus.addr = 2'd0; bus.usr_id = 2'd0; bus.wr_data = 8'h00;
        model_clear();
        do_reset();

        send(2'b10, 1, 2'd1, 8'h00);
        send(2'b01, 1, 2'd1, 8'hA5);
        send(2'b01, 1, 2'd2, 8'h3C);
        send(2'b11, 1, ADMIN, 8'h00);
        send(2'b01, 1, 2'd1, 8'h77);
        send(2'b10, 3, 2'd1, 8'h00);
        send(2'b00, 3, 2'd0, 8'h00);
        send(2'b10, 2, ADMIN, 8'h00);
        send(2'b01, 2, 2'd1, 8'h42);
        send(2'b11, 2, 2'd3, 8'h00);
        send(2'b11, 2, 2'd3, 8'h00);
        idle(2);

        send(2'b10, 0, 2'd2, 8'h00);
        send(2'b01, 0, 2'd2, 8'h11);
        do_reset();

        if (AUTO) begin
            send(2'b10, 2, 2'd0, 8'h00);
            e0 = edge_cnt + 1;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                bus.req = 1'b0;
                chk("auto_idle_lock", 32'(bus.locked[2]), 32'(edge_cnt < e0 + TO));
            end
            send(2'b10, 2, 2'd0, 8'h00);
            e0 = edge_cnt + 1;
            idle(TO - 1);
            send(2'b01, 2, 2'd0, 8'h5A);
            for (int k = 0; k < 6; k++) begin
                @(posedge clk);
                #1;
                bus.req = 1'b0;
                chk("auto_refresh_lock", 32'(bus.locked[2]), 32'(edge_cnt < e0 + 2 * TO));
            end
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                send(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 8'($urandom));
            end
        end

        for (int n = 0; n < 300; n++) begin
            send(2'b10, 3, 2'($urandom_range(0, 3)), 8'h00);
        end
        idle(2);
        chk("viol_saturated", 32'(bus.viol_cnt), 32'h0000_00FF);

        idle(3);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
